// File: rtl/mem_access_ctrl.sv
// Single-port memory access sequencer: IDLE -> ACCESS (WAIT_STATES+1 cycles) -> DONE -> IDLE.
// Requests are level-sampled only in IDLE; anything arriving while busy is dropped, never queued.
module mem_access_ctrl #(
  parameter int ADDR_W      = 15,
  parameter int DATA_W      = 16,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd_req,
  input  logic              wr_req,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] next_addr,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0]        WAIT_CNT = 4'(WAIT_STATES);
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_op_q, wr_op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_op_d     = wr_op_q;
    addr_d      = addr_q;
    next_addr_d = next_addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (rd_req ^ wr_req) begin
          state_d     = ACCESS;
          cnt_d       = WAIT_CNT;
          wr_op_d     = wr_req;
          addr_d      = addr_in;
          wdata_d     = wdata;
          next_addr_d = addr_in + ADDR_ONE;
        end else if (rd_req && wr_req) begin
          err_d = 1'b1;
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // mem_rdata is only guaranteed valid in the final ACCESS cycle
          state_d = DONE;
          done_d  = 1'b1;
          if (!wr_op_q) rdata_d = mem_rdata;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so mem_* never see rd_req/wr_req combinationally
    busy_d   = (state_d != IDLE);
    mem_en_d = (state_d == ACCESS);
    mem_we_d = (state_d == ACCESS) && wr_op_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_op_q     <= 1'b0;
      addr_q      <= '0;
      next_addr_q <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_op_q     <= wr_op_d;
      addr_q      <= addr_d;
      next_addr_q <= next_addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign next_addr = next_addr_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule
